multiwave_sum: RTL and testbench
================================

# multiwave_sum

Parametrised N-channel waveform synthesiser and mixer; the generalised successor of the two-channel compute/add pair. On each `sample_en` tick it advances NCH phase accumulators. It then evaluates one channel per cycle through a single shared waveform/multiply engine, accumulates the terms, and presents the (optionally saturated) mix with a one-cycle `out_valid` strobe. It sits between the control register file and the DAC output stage.

## Interface
- NCH, 4, channel count (2..16)
- AW, 16, amplitude and waveform width (signed)
- PW, 16, phase accumulator width (PW >= AW)
- OW, 16, output sample width (signed)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- sample_en  in  1  sample tick request
- cfg_we  in  1  config write strobe
- cfg_ready  out  1  high when config writes are accepted (state IDLE)
- cfg_ch  in  clog2(NCH)  target channel
- cfg_sel  in  2  field select: 0 amp, 1 phase offset, 2 phase word, 3 mode
- cfg_data  in  max(AW,PW)  write data, LSB-aligned
- results  out  OW  signed mixed sample
- out_valid  out  1  one-cycle strobe: new `results`
- overrun  out  1  sticky: `sample_en` arrived while busy

## Operation
- Per channel: `amp` (signed AW), `offset` (PW), `pword` (PW), `mode` (2b), `acc` (PW). All reset to 0; mode 0 is saw.
- Config write occurs when `cfg_we && cfg_ready`. The write updates the selected field at that edge and is ignored otherwise. Writing a channel index >= NCH is ignored.
- FSM states: IDLE, ADVANCE, ACCUM, DONE.
  - IDLE: if `sample_en`, go to ADVANCE.
  - ADVANCE: every `acc += pword`, mod 2^PW. Clear `sum` and `ch`. Go to ACCUM.
  - ACCUM: `sum += term(ch)`, `ch++`. After ch = NCH-1, go to DONE.
  - DONE: `results <= out(sum)`, `out_valid <= 1`. Go to IDLE.
- Waveform generation:
  - p = acc + offset (mod 2^PW); u = p[PW-1 -: AW] (unsigned).
  - mode 0, saw: w = u - 2^(AW-1).
  - mode 1, triangle: f = (u << 1) mod 2^AW if u[AW-1] = 0, else ~(u << 1) mod 2^AW; w = f - 2^(AW-1).
  - mode 2, square: w = +(2^(AW-1)-1) if p[PW-1] = 0, else -(2^(AW-1)-1).
  - mode 3, mute: w = 0.
- term = (w * amp) >>> (AW-1). The product is a full 2AW-bit signed value; the shift is arithmetic (floor).
- `sum` width is AW+1+clog2(NCH) bits and never overflows internally.
- `sample_en` in any non-IDLE state is dropped and sets `overrun`. `overrun` clears only on reset.
- `cfg_ready` = (state == IDLE).

## Timing
- Reset, asynchronous assert: state IDLE; all channel registers 0; `sum` 0; `results` 0; `out_valid` 0; `overrun` 0; `cfg_ready` 1.
- Latency: `sample_en` sampled at edge E leads to `results` and `out_valid` updating at edge E+NCH+2. `out_valid` is high for exactly one cycle.
- Maximum sample rate is one sample per NCH+3 cycles. `sample_en` asserted during the `out_valid` cycle (IDLE) is accepted.
- Reset mid-operation aborts the sample: no `out_valid`, and all accumulators are zero.
- Phase wrap: `acc` wraps silently modulo 2^PW.

## Configuration
- WAVESUM_SAT_EN defined: `out(sum)` clamps to [-2^(OW-1), 2^(OW-1)-1].
- WAVESUM_SAT_EN undefined: `out(sum)` = sum[OW-1:0] (two's-complement wrap).

## Test plan
NCH=4, AW=PW=OW=16.
1. Reset, then idle 10 cycles -> `results` = 0, `out_valid` = 0, `overrun` = 0, `cfg_ready` = 1.
2. Ch0 square, amp 0x4000; ch1-3 mode 3; one `sample_en` -> exactly 6 edges later `results` = 16383 with a single `out_valid` pulse.
3. All four channels square, amp 0x7FFF, one tick -> each term = 32766. With SAT_EN, `results` = 32767. Without SAT_EN, `results` = -8.
4. Ch0 saw, amp 0x7FFF, pword 0x4000, others muted; four ticks -> `results` sequence is -16384, 0, 16383, -32767 (phases 0x4000, 0x8000, 0xC000, 0x0000 wrap).
5. `sample_en` held high for 3 cycles -> one sample produced, `overrun` = 1 and stays 1. Config write during ACCUM -> `cfg_ready` = 0 and the register is unchanged.
6. Reset pulsed during ACCUM -> no `out_valid`. A fresh tick on muted channels yields `results` = 0.

Source files
------------

// File: rtl/multiwave_sum_if.sv
// multiwave_sum bus: sample tick, config port and mixed-sample output.
interface multiwave_sum_if #(
  parameter int NCH = 4,
  parameter int AW  = 16,
  parameter int PW  = 16,
  parameter int OW  = 16
);
  localparam int CW = $clog2(NCH);
  localparam int DW = (AW > PW) ? AW : PW;

  logic                 sample_en;
  logic                 cfg_we;
  logic                 cfg_ready;
  logic [CW-1:0]        cfg_ch;
  logic [1:0]           cfg_sel;
  logic [DW-1:0]        cfg_data;
  logic signed [OW-1:0] results;
  logic                 out_valid;
  logic                 overrun;

  modport master (
    output sample_en, cfg_we, cfg_ch, cfg_sel, cfg_data,
    input  cfg_ready, results, out_valid, overrun
  );

  modport slave (
    input  sample_en, cfg_we, cfg_ch, cfg_sel, cfg_data,
    output cfg_ready, results, out_valid, overrun
  );
endinterface

// File: rtl/multiwave_sum.sv
// N-channel waveform synthesiser/mixer, one shared multiply per channel.
// Define WAVESUM_SAT_EN to clamp the mix instead of wrapping it.
module multiwave_sum #(
  parameter int NCH = 4,
  parameter int AW  = 16,
  parameter int PW  = 16,
  parameter int OW  = 16
) (
  input logic clk,
  input logic reset,
  multiwave_sum_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int SW = AW + 1 + CW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADV  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [AW-1:0] SQ =
    {1'b0, {(AW-1){1'b1}}};

  logic signed [AW-1:0] amp    [NCH];
  logic [PW-1:0]        offset [NCH];
  logic [PW-1:0]        pword  [NCH];
  logic [1:0]           mode   [NCH];
  logic [PW-1:0]        acc    [NCH];

  logic [1:0]           state;
  logic [CW-1:0]        ch;
  logic signed [SW-1:0] sum;
  logic signed [OW-1:0] results;
  logic                 out_valid;
  logic                 overrun;

  logic                   wr_en;
  logic [PW-1:0]          p;
  logic [AW-1:0]          u;
  logic [AW-1:0]          f;
  logic signed [AW-1:0]   w;
  logic signed [2*AW-1:0] prod;
  logic signed [AW:0]     term;
  logic signed [OW-1:0]   out_c;

  assign wr_en = bus.cfg_we && (state == S_IDLE) &&
                 (32'(bus.cfg_ch) < NCH);

  always_comb begin
    p = acc[ch] + offset[ch];
    u = p[PW-1 -: AW];
    f = u;
    w = '0;
    unique case (mode[ch])
      2'd0: w = {~u[AW-1], u[AW-2:0]};
      2'd1: begin
        f = u[AW-1] ? ~{u[AW-2:0], 1'b0}
                    :  {u[AW-2:0], 1'b0};
        w = {~f[AW-1], f[AW-2:0]};
      end
      2'd2: w = p[PW-1] ? -SQ : SQ;
      2'd3: w = '0;
    endcase
    prod = w * amp[ch];
    term = (AW+1)'(prod >>> (AW-1));
  end

`ifdef WAVESUM_SAT_EN
  localparam int XW = SW + OW;
  localparam logic signed [XW-1:0] OMAX =
    {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN = ~OMAX;
  logic signed [XW-1:0] sum_x;

  always_comb begin
    sum_x = XW'(sum);
    if (sum_x > OMAX)
      out_c = OMAX[OW-1:0];
    else if (sum_x < OMIN)
      out_c = OMIN[OW-1:0];
    else
      out_c = sum_x[OW-1:0];
  end
`else
  assign out_c = OW'(sum);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        amp[i]    <= '0;
        offset[i] <= '0;
        pword[i]  <= '0;
        mode[i]   <= '0;
        acc[i]    <= '0;
      end
    end else begin
      if (state == S_ADV)
        for (int i = 0; i < NCH; i++)
          acc[i] <= acc[i] + pword[i];
      if (wr_en)
        unique case (bus.cfg_sel)
          2'd0: amp[bus.cfg_ch]    <= bus.cfg_data[AW-1:0];
          2'd1: offset[bus.cfg_ch] <= bus.cfg_data[PW-1:0];
          2'd2: pword[bus.cfg_ch]  <= bus.cfg_data[PW-1:0];
          2'd3: mode[bus.cfg_ch]   <= bus.cfg_data[1:0];
        endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ch        <= '0;
      sum       <= '0;
      results   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (bus.sample_en && state != S_IDLE)
        overrun <= 1'b1;
      unique case (state)
        S_IDLE: if (bus.sample_en) state <= S_ADV;
        S_ADV: begin
          sum   <= '0;
          ch    <= '0;
          state <= S_ACC;
        end
        S_ACC: begin
          sum <= sum + SW'(term);
          ch  <= ch + CW'(1);
          if (ch == CW'(NCH - 1)) state <= S_DONE;
        end
        S_DONE: begin
          results   <= out_c;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready = (state == S_IDLE);
  assign bus.results   = results;
  assign bus.out_valid = out_valid;
  assign bus.overrun   = overrun;
endmodule

// File: tb/tb_multiwave_sum.sv
// Directed bench for multiwave_sum, NCH=4, AW=PW=OW=16.
module tb_multiwave_sum;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int passed = 0;
  int total = 0;

  multiwave_sum_if #(.NCH(4), .AW(16), .PW(16), .OW(16)) bus ();

  multiwave_sum #(.NCH(4), .AW(16), .PW(16), .OW(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cfg_write(input logic [1:0] ch,
                           input logic [1:0] sel,
                           input logic [15:0] data);
    bus.cfg_ch   = ch;
    bus.cfg_sel  = sel;
    bus.cfg_data = data;
    bus.cfg_we   = 1'b1;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_valid(output logic signed [15:0] res);
    int n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      total++;
      $display("FAIL wait_valid: out_valid=0 after %0d cycles, required 1", n);
      res = 'x;
    end else begin
      res = bus.results;
    end
  endtask

  task automatic run_sample(output logic signed [15:0] res);
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    wait_valid(res);
  endtask

  task automatic test_reset();
    repeat (10) @(negedge clk);
    total++;
    if (bus.results !== 16'sd0)
      $display("FAIL reset_results: got %0d want 0", bus.results);
    else passed++;
    total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    else passed++;
    total++;
    if (bus.overrun !== 1'b0)
      $display("FAIL reset_overrun: got %b want 0", bus.overrun);
    else passed++;
    total++;
    if (bus.cfg_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", bus.cfg_ready);
    else passed++;
  endtask

  task automatic test_square_latency();
    int pulses = 0;
    int at = 0;
    logic signed [15:0] res = '0;
    cfg_write(2'd0, 2'd3, 16'd2);
    cfg_write(2'd0, 2'd0, 16'h4000);
    for (int c = 1; c < 4; c++)
      cfg_write(2'(c), 2'd3, 16'd3);
    bus.sample_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.sample_en = 1'b0;
      if (bus.out_valid) begin
        pulses++;
        at = k;
        res = bus.results;
      end
    end
    total++;
    if (pulses !== 1)
      $display("FAIL sq_pulses: got %0d want 1", pulses);
    else passed++;
    total++;
    if (at !== 7)
      $display("FAIL sq_latency: pulse after edge E+%0d want E+6", at - 1);
    else passed++;
    total++;
    if (res !== 16'sd16383)
      $display("FAIL sq_result: got %0d want 16383", res);
    else passed++;
  endtask

  task automatic test_saturation();
    logic signed [15:0] res;
    logic signed [15:0] exp;
`ifdef WAVESUM_SAT_EN
    exp = 16'sd32767;
`else
    exp = -16'sd8;
`endif
    for (int c = 0; c < 4; c++) begin
      cfg_write(2'(c), 2'd3, 16'd2);
      cfg_write(2'(c), 2'd0, 16'h7FFF);
    end
    run_sample(res);
    total++;
    if (res !== exp)
      $display("FAIL sat_result: got %0d want %0d", res, exp);
    else passed++;
  endtask

  task automatic test_back_to_back_saw();
    logic signed [15:0] res;
    logic signed [15:0] exp [4];
    exp[0] = -16'sd16384;
    exp[1] = 16'sd0;
    exp[2] = 16'sd16383;
    exp[3] = -16'sd32767;
    cfg_write(2'd0, 2'd3, 16'd0);
    cfg_write(2'd0, 2'd0, 16'h7FFF);
    cfg_write(2'd0, 2'd2, 16'h4000);
    for (int c = 1; c < 4; c++)
      cfg_write(2'(c), 2'd3, 16'd3);
    for (int i = 0; i < 4; i++) begin
      run_sample(res);
      total++;
      if (res !== exp[i])
        $display("FAIL saw_%0d: got %0d want %0d", i, res, exp[i]);
      else passed++;
    end
    total++;
    if (bus.overrun !== 1'b0)
      $display("FAIL b2b_overrun: got %b want 0", bus.overrun);
    else passed++;
  endtask

  task automatic test_overrun();
    int pulses = 0;
    logic signed [15:0] res = '0;
    bus.sample_en = 1'b1;
    repeat (3) @(negedge clk);
    bus.sample_en = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (bus.out_valid) begin
        pulses++;
        res = bus.results;
      end
      @(negedge clk);
    end
    total++;
    if (pulses !== 1)
      $display("FAIL ovr_pulses: got %0d want 1", pulses);
    else passed++;
    total++;
    if (res !== -16'sd16384)
      $display("FAIL ovr_result: got %0d want -16384", res);
    else passed++;
    total++;
    if (bus.overrun !== 1'b1)
      $display("FAIL ovr_set: got %b want 1", bus.overrun);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (bus.overrun !== 1'b1)
      $display("FAIL ovr_sticky: got %b want 1", bus.overrun);
    else passed++;
  endtask

  task automatic test_cfg_busy();
    logic signed [15:0] res;
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    @(negedge clk);
    total++;
    if (bus.cfg_ready !== 1'b0)
      $display("FAIL busy_ready: got %b want 0", bus.cfg_ready);
    else passed++;
    cfg_write(2'd1, 2'd3, 16'd2);
    wait_valid(res);
    total++;
    if (res !== 16'sd0)
      $display("FAIL busy_sample: got %0d want 0", res);
    else passed++;
    @(negedge clk);
    run_sample(res);
    total++;
    if (res !== 16'sd16383)
      $display("FAIL busy_unchanged: got %0d want 16383", res);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic signed [15:0] res;
    @(negedge clk);
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    total++;
    if (pulses !== 0)
      $display("FAIL mid_pulses: got %0d want 0", pulses);
    else passed++;
    total++;
    if (bus.results !== 16'sd0)
      $display("FAIL mid_results: got %0d want 0", bus.results);
    else passed++;
    total++;
    if (bus.overrun !== 1'b0)
      $display("FAIL mid_overrun: got %b want 0", bus.overrun);
    else passed++;
    cfg_write(2'd0, 2'd3, 16'd2);
    cfg_write(2'd0, 2'd0, 16'h4000);
    for (int c = 1; c < 4; c++)
      cfg_write(2'(c), 2'd3, 16'd3);
    run_sample(res);
    total++;
    if (res !== 16'sd16383)
      $display("FAIL mid_acc_zero: got %0d want 16383", res);
    else passed++;
    @(negedge clk);
    cfg_write(2'd0, 2'd3, 16'd3);
    run_sample(res);
    total++;
    if (res !== 16'sd0)
      $display("FAIL mid_muted: got %0d want 0", res);
    else passed++;
  endtask

  initial begin
    bus.sample_en = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_sel   = '0;
    bus.cfg_data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_square_latency();
    test_saturation();
    test_back_to_back_saw();
    test_overrun();
    test_cfg_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
